// File: rtl/decade_pkg.sv
// decade_pkg: shared definitions for the decade timer controller and its
// digit datapath.
//   state_t        controller states (IDLE, RUN, PAUSED, DONE)
//   BCD_MAX        largest legal BCD digit value
//   clamp_bcd()    forces an out-of-range nibble down to BCD_MAX
package decade_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/decade_digit.sv
// decade_digit: one mod-10 BCD digit.
//   clk     rising-edge clock
//   rstn    asynchronous active-low reset, clears the digit
//   en      increment this digit at the next edge (wraps 9 -> 0)
//   clr     synchronous clear, wins over en
//   out     current digit value
//   at_max  digit currently holds 9; feeds the controller's carry chain
module decade_digit
    import decade_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] out,
    output logic       at_max
);

    logic [3:0] out_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= 4'd0;
        end else if (clr) begin
            out_q <= 4'd0;
        end else if (en) begin
            out_q <= (out_q == BCD_MAX) ? 4'd0 : out_q + 4'd1;
        end
    end

    assign out    = out_q;
    assign at_max = (out_q == BCD_MAX);

endmodule

// File: rtl/decade_timer_ctrl.sv
// decade_timer_ctrl: start/pause/clear sequencer driving a cascade of decade
// digits up to a captured BCD target.
//   DIGITS    number of cascaded BCD digits (count/target are 4*DIGITS wide)
//   PRESCALE  clocks per count tick while running (>= 1)
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   start     begin / resume / restart command (level-sampled)
//   pause     freeze the count while running (level-sampled)
//   clear     zero the count and return to idle (level-sampled, top priority)
//   target    BCD terminal value, captured when a start is accepted
//   count     current BCD count
//   busy      high in RUN and PAUSED
//   tick      combinational: an increment happens at the next edge
//   done      one-cycle registered pulse when the count reaches the target
module decade_timer_ctrl
    import decade_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  tick,
    output logic                  done
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   target_q, target_d;
    logic                  done_q, done_d;

    logic                  digit_clr;
    logic [DIGITS-1:0]     digit_en;
    logic [DIGITS-1:0]     at_max;
    logic [4*DIGITS-1:0]   count_next;
    logic [4*DIGITS-1:0]   target_clamped;
    logic                  hit;

    // ------------------------------------------------------------------
    // Digit datapath
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        decade_digit u_digit (
            .clk    (clk),
            .rstn   (rstn),
            .en     (digit_en[k]),
            .clr    (digit_clr),
            .out    (count[4*k +: 4]),
            .at_max (at_max[k])
        );
    end

    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST) && !clear && !pause;

    // Ripple carry: digit k steps when the tick reaches it through all lower
    // digits sitting at 9. count_next mirrors what the digits will hold after
    // the edge so the terminal compare can fire on the same edge.
    always_comb begin
        logic carry;
        carry      = tick;
        digit_en   = '0;
        count_next = count;
        for (int k = 0; k < DIGITS; k++) begin
            digit_en[k] = carry;
            if (carry) begin
                count_next[4*k +: 4] = at_max[k] ? 4'd0 : count[4*k +: 4] + 4'd1;
            end
            carry = carry & at_max[k];
        end
    end

    always_comb begin
        target_clamped = '0;
        for (int k = 0; k < DIGITS; k++) begin
            target_clamped[4*k +: 4] = clamp_bcd(target[4*k +: 4]);
        end
    end

    assign hit = tick && (count_next == target_q);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        target_d  = target_q;
        done_d    = 1'b0;
        digit_clr = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            presc_d   = '0;
            digit_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        target_d  = target_clamped;
                        presc_d   = '0;
                        digit_clr = 1'b1;
                        if (target_clamped == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // start is ignored here; pause freezes prescaler and count.
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        if (hit) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN) || (state_q == PAUSED);
    assign done = done_q;

endmodule

// File: doc/decade_timer_ctrl.md
# decade_timer_ctrl

Sequencing controller for a cascade of mod-10 decade counters. It turns start/pause/clear commands into gated count enables and prescales `clk` into count ticks. It runs the BCD count up to a programmable target and signals completion. The block sits between the control logic and the decade-digit datapath, and it owns and instantiates that datapath.

## Interface
- `DIGITS`, default 2: number of cascaded decade digits; `count`/`target` width = 4*DIGITS.
- `PRESCALE`, default 4: clocks per count tick while running; legal range ≥1.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  level-sampled command: begin, resume or restart.
- `pause`  in  1  level-sampled command: freeze count while running.
- `clear`  in  1  level-sampled command: zero count and return to idle.
- `target`  in  4*DIGITS  BCD terminal value; digit 0 in bits [3:0]; sampled only when a start is accepted.
- `count`  out  4*DIGITS  current BCD count, registered.
- `busy`  out  1  high in RUN and PAUSED.
- `tick`  out  1  combinational strobe; high for one cycle when a count increment occurs at the next edge.
- `done`  out  1  registered one-cycle pulse when count reaches the captured target.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Command priority: clear > start > pause. Commands are evaluated every rising edge.
- clear, any state: next state IDLE; count, prescaler and done go to 0. The captured target is kept.
- start in IDLE or DONE:
  - captures `target`, zeroes count and prescaler.
  - next state RUN, or DONE with a done pulse if the captured target is 0.
- start in PAUSED: resume to RUN; prescaler and count are unchanged.
- start in RUN: ignored.
- pause in RUN: next state PAUSED; prescaler and count hold.
- pause in any other state: ignored.
- Prescaler: counts 0..PRESCALE-1 in RUN only, then wraps to 0. `tick` = (state==RUN) && (prescaler==PRESCALE-1) && !clear && !pause. A pause or clear in the same cycle suppresses the tick.
- Digit cascade, on tick:
  - digit 0 increments.
  - digit k increments when all lower digits equal 9.
  - a digit at 9 wraps to 0.
- Target capture: any nibble >9 is clamped to 9.
- Terminal condition: on the tick edge where the new count equals the captured target, the state goes to DONE and done=1 for exactly that following cycle. Count holds at target in DONE.
- The count cannot run past the target, because every clamped target is reachable. Wrap of the full cascade (all 9s → 0) therefore never occurs in normal operation.

## Timing
- Reset (async assert): state IDLE, count 0, prescaler 0, done 0, busy 0. tick is 0 as a consequence of the state. Deassertion takes effect at the next rising edge.
- start accepted at edge E: busy=1 from E. First tick is in the cycle before edge E+PRESCALE, and count=1 after edge E+PRESCALE.
- Latency from start to done for target T (T≠0, decimal value): done is high in the cycle after edge E+T·PRESCALE. busy drops on that same edge.
- Target 0: done pulses in the cycle after the accepting edge, and busy stays 0.
- Pause for P cycles adds exactly P+1 cycles to the done latency: the pause cycle plus the start (resume) cycle.
- clear while done is high: done drops at the next edge.

## Structure
- Shared package `decade_pkg`:
  - state enum (IDLE, RUN, PAUSED, DONE)
  - constant `BCD_MAX = 4'd9`
  - nibble clamp function
- Sub-module `decade_digit`: one mod-10 digit with ports `clk`, `rstn`, `en`, `clr`, `out[3:0]`, `at_max`. It is instantiated DIGITS times. The carry chain is built from `at_max` in the controller.
- Controller holds the FSM, prescaler ($clog2(PRESCALE) bits, minimum 1), target register and done register.

## Test plan
- Reset mid-run: DIGITS=2, PRESCALE=4, target=0x12; assert rstn low at count=0x05 → count=0x00, busy=0, done=0 immediately, without waiting for a clock.
- Basic run: target=0x12, start for 1 cycle → count steps 01..12 every 4 clocks. done pulses once, 48 cycles after the start edge. count holds 0x12 in DONE.
- Carry: target=0x25 → sequence passes 0x09→0x10 and 0x19→0x20 on single ticks, with no skipped values.
- Pause/resume: pause 10 cycles at count=0x03, then start → count frozen at 0x03 throughout the pause, and done latency grows by exactly 11 cycles.
- Priority: clear, start and pause all high together in RUN → IDLE, count 0x00. start+pause together in PAUSED → resumes RUN.
- Edge targets:
  - target=0x00 → done pulse one cycle after start, busy never high.
  - target=0xAF → clamped to 0x99; done after 99·4 cycles.
  - start in RUN is ignored: count continues, target is unchanged.
